// File: rtl/tone_pkg.sv
// Shared note table, rounding helper and state type for the tone player.
package tone_pkg;

  localparam int NUM_NOTES = 12;

  // Codes at or above this value play silence with normal note timing.
  localparam logic [3:0] REST_CODE = 4'd12;

  localparam int NOTE_HZ [NUM_NOTES] = '{
    440, 466, 494, 523, 554, 587, 622, 659, 698, 740, 784, 831
  };

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } playerState_t;

  function automatic int half_period(input int f, input int clkHz);
    return (clkHz + f) / (2 * f);
  endfunction

endpackage

// File: rtl/tone_player_if.sv
// Command/status bundle between the note sequencer and the tone player.
interface tone_player_if #(
  parameter int DUR_W = 12
);
  logic             start;
  logic [3:0]       noteSelect;
  logic [1:0]       octave;
  logic [DUR_W-1:0] duration;
  logic             stop;
  logic             busy;
  logic             done;
  logic             pwmPin;
  logic             ampPin;

  modport master (
    output start, noteSelect, octave, duration, stop,
    input  busy, done, pwmPin, ampPin
  );

  modport slave (
    input  start, noteSelect, octave, duration, stop,
    output busy, done, pwmPin, ampPin
  );
endinterface

// File: rtl/tick_gen.sv
// Duration prescaler: one-cycle tick every DIVIDE clocks, restartable by clear.
module tick_gen #(
  parameter int DIVIDE = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic tickNext
);
  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(DIVIDE - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // tickNext lets the owner register an output that must coincide with tick.
  assign tick     = (count == LAST);
  assign tickNext = (count == PRE_LAST);
endmodule

// File: rtl/tone_player.sv
// Single-voice square-wave note player: latches a command, plays it for the
// requested number of ticks, then holds a silent gap before going idle.
module tone_player
  import tone_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int DUR_W     = 12,
  parameter int GAP_TICKS = 20,
  parameter int HP_W      = 18
) (
  input logic          clk,
  input logic          rst,
  tone_player_if.slave bus
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int GAP_W    = $clog2(GAP_TICKS + 1);
  localparam int CNT_W    = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

  function automatic logic [NUM_NOTES-1:0][HP_W-1:0] buildHpTable();
    logic [NUM_NOTES-1:0][HP_W-1:0] t;
    for (int i = 0; i < NUM_NOTES; i++) begin
      t[i] = HP_W'(half_period(NOTE_HZ[i], CLK_HZ));
    end
    return t;
  endfunction

  localparam logic [NUM_NOTES-1:0][HP_W-1:0] HP_TABLE = buildHpTable();

  playerState_t     state;
  logic [CNT_W-1:0] tickCount;
  logic [CNT_W-1:0] durLast;
  logic [DUR_W-1:0] durLatched;
  logic [HP_W-1:0]  hpLatched;
  logic [HP_W-1:0]  hpCount;
  logic [HP_W-1:0]  hpNext;
  logic             isRest;
  logic             noteIsRest;
  logic             accept;
  logic             tick;
  logic             tickNext;

  assign noteIsRest = (bus.noteSelect >= REST_CODE);
  assign hpNext     = noteIsRest ? '0 : (HP_TABLE[bus.noteSelect] >> bus.octave);
  assign accept     = (state == IDLE) && bus.start;
  assign durLast    = CNT_W'(durLatched) - CNT_W'(1);

  tick_gen #(
    .DIVIDE(TICK_DIV)
  ) tickGen (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .tick     (tick),
    .tickNext (tickNext)
  );

  // Control FSM; the wave is cut wherever it is when the duration expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tickCount  <= '0;
      durLatched <= '0;
      hpLatched  <= '0;
      hpCount    <= '0;
      isRest     <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.pwmPin <= 1'b0;
      bus.ampPin <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            durLatched <= bus.duration;
            hpLatched  <= hpNext;
            isRest     <= noteIsRest;
            tickCount  <= '0;
            hpCount    <= '0;
            bus.busy   <= 1'b1;
            if (bus.duration == '0) begin
              state      <= GAP;
              bus.ampPin <= 1'b0;
              bus.pwmPin <= 1'b0;
            end else begin
              state      <= PLAY;
              bus.ampPin <= !noteIsRest;
              bus.pwmPin <= !noteIsRest;
            end
          end
        end

        PLAY: begin
          if (bus.stop) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.ampPin <= 1'b0;
            bus.pwmPin <= 1'b0;
          end else begin
            if (hpCount == hpLatched - HP_W'(1)) begin
              hpCount <= '0;
              if (!isRest) begin
                bus.pwmPin <= !bus.pwmPin;
              end
            end else begin
              hpCount <= hpCount + HP_W'(1);
            end
            if (tick) begin
              if (tickCount == durLast) begin
                state      <= GAP;
                tickCount  <= '0;
                bus.ampPin <= 1'b0;
                bus.pwmPin <= 1'b0;
              end else begin
                tickCount <= tickCount + CNT_W'(1);
              end
            end
          end
        end

        GAP: begin
          if (bus.stop) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            // done is raised one clock early so it lands on the final GAP cycle.
            if (tickNext && tickCount == GAP_LAST) begin
              bus.done <= 1'b1;
            end
            if (tick) begin
              if (tickCount == GAP_LAST) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end else begin
                tickCount <= tickCount + CNT_W'(1);
              end
            end
          end
        end

        default: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.ampPin <= 1'b0;
          bus.pwmPin <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player: table vectors, hand-written corner
// sequences and random notes checked against a cycle-level waveform model.
module tb_tone_player;
  localparam int CLK_HZ = 1_000_000;
  localparam int TICK_HZ = 1000;
  localparam int P = CLK_HZ / TICK_HZ;
  localparam int GAP_TICKS = 1;
  localparam int FREQ_HZ [12] = '{440, 466, 494, 523, 554, 587, 622, 659, 698, 740, 784, 831};

  typedef struct {
    int ampCycles;
    int busyCycles;
    int firstToggle;
    int doneCycle;
    int doneCount;
    int modelMismatch;
  } meas_t;

  typedef struct {
    int note;
    int oct;
    int dur;
    int expToggle;
    int expAmp;
    int expBusy;
    int expDone;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tone_player_if #(.DUR_W(12)) bus ();

  tone_player #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .DUR_W     (12),
    .GAP_TICKS (GAP_TICKS),
    .HP_W      (18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int modelHp(input int note, input int oct);
    real exact;
    if (note >= 12) return 0;
    exact = real'(CLK_HZ) / (2.0 * real'(FREQ_HZ[note]));
    return $rtoi(exact + 0.5) >> oct;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Issues one command at a negedge and follows it until busy falls.
  task automatic applyStimulus(input int note, input int oct, input int dur, output meas_t m);
    int  hp;
    int  busyLen;
    int  k;
    bit  prevPwm;
    bit  expAmp;
    bit  expPwm;
    bit  expDone;
    m = '{ampCycles: 0, busyCycles: 0, firstToggle: -1, doneCycle: -1,
           doneCount: 0, modelMismatch: 0};
    hp = modelHp(note, oct);
    busyLen = (dur + GAP_TICKS) * P;
    bus.noteSelect = 4'(note);
    bus.octave = 2'(oct);
    bus.duration = 12'(dur);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    prevPwm = 1'b0;
    while (bus.busy && k < busyLen + 10) begin
      expAmp = (note < 12) && (k < dur * P);
      expPwm = expAmp && hp > 0 && ((k / hp) % 2 == 0);
      expDone = (k == busyLen - 1);
      if (bus.ampPin !== expAmp || bus.pwmPin !== expPwm || bus.done !== expDone)
        m.modelMismatch++;
      if (bus.ampPin) m.ampCycles++;
      m.busyCycles++;
      if (bus.done) begin
        m.doneCount++;
        if (m.doneCycle < 0) m.doneCycle = k;
      end
      if (k > 0 && bus.ampPin && bus.pwmPin != prevPwm && m.firstToggle < 0)
        m.firstToggle = k;
      prevPwm = bus.pwmPin;
      k++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t  vecs [5];
    meas_t m;
    int    cnt;
    int    note;
    int    oct;
    int    dur;

    vecs[0] = '{0, 0, 3, 1136, 3000, 4000, 3999};
    vecs[1] = '{11, 2, 1, 150, 1000, 2000, 1999};
    vecs[2] = '{13, 0, 2, -1, 0, 3000, 2999};
    vecs[3] = '{5, 1, 0, -1, 0, 1000, 999};
    vecs[4] = '{3, 3, 1, 119, 1000, 2000, 1999};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.noteSelect = '0;
    bus.octave = '0;
    bus.duration = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", int'(bus.busy), 0);
    checkOutput("rstDone", int'(bus.done), 0);
    checkOutput("rstPwm", int'(bus.pwmPin), 0);
    checkOutput("rstAmp", int'(bus.ampPin), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleBusy", int'(bus.busy), 0);
    checkOutput("idleAmp", int'(bus.ampPin), 0);

    // Table vectors run back-to-back: each start lands on the first idle cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].note, vecs[i].oct, vecs[i].dur, m);
      checkOutput($sformatf("vec%0d.ampCycles", i), m.ampCycles, vecs[i].expAmp);
      checkOutput($sformatf("vec%0d.busyCycles", i), m.busyCycles, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d.firstToggle", i), m.firstToggle, vecs[i].expToggle);
      checkOutput($sformatf("vec%0d.doneCycle", i), m.doneCycle, vecs[i].expDone);
      checkOutput($sformatf("vec%0d.doneCount", i), m.doneCount, 1);
      checkOutput($sformatf("vec%0d.model", i), m.modelMismatch, 0);
    end

    // A second start during a note is ignored and does not stretch it.
    @(negedge clk);
    bus.noteSelect = 4'd2;
    bus.octave = 2'd0;
    bus.duration = 12'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 2100 && bus.busy; k++) begin
      if (k == 100) begin
        bus.duration = 12'd3;
        bus.noteSelect = 4'd0;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput("ignoredStart.busyCycles", cnt, 2000);

    // Stop 500 cycles into PLAY: outputs drop next cycle and no done follows.
    @(negedge clk);
    bus.noteSelect = 4'd0;
    bus.duration = 12'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (500) @(negedge clk);
    checkOutput("preStop.amp", int'(bus.ampPin), 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    checkOutput("stop.busy", int'(bus.busy), 0);
    checkOutput("stop.pwm", int'(bus.pwmPin), 0);
    checkOutput("stop.amp", int'(bus.ampPin), 0);
    cnt = 0;
    for (int k = 0; k < 4500; k++) begin
      if (bus.done || bus.busy) cnt++;
      @(negedge clk);
    end
    checkOutput("stop.noDoneOrBusy", cnt, 0);

    // Stop alone in IDLE does nothing; start with stop in IDLE is accepted.
    bus.stop = 1'b1;
    @(negedge clk);
    checkOutput("idleStop.busy", int'(bus.busy), 0);
    bus.noteSelect = 4'd4;
    bus.duration = 12'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    checkOutput("startWins.busy", int'(bus.busy), 1);
    repeat (10) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    checkOutput("stopInGap.busy", int'(bus.busy), 0);
    checkOutput("stopInGap.done", int'(bus.done), 0);

    // Asynchronous reset between clock edges in the middle of a note.
    @(negedge clk);
    bus.noteSelect = 4'd0;
    bus.duration = 12'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("preRst.amp", int'(bus.ampPin), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRst.pwm", int'(bus.pwmPin), 0);
    checkOutput("asyncRst.amp", int'(bus.ampPin), 0);
    checkOutput("asyncRst.busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRst.busy", int'(bus.busy), 0);
    applyStimulus(0, 0, 0, m);
    checkOutput("postRst.busyCycles", m.busyCycles, P * GAP_TICKS);

    // Random notes against the waveform model.
    for (int i = 0; i < 6; i++) begin
      note = int'($urandom_range(0, 15));
      oct = int'($urandom_range(0, 3));
      dur = int'($urandom_range(0, 2));
      applyStimulus(note, oct, dur, m);
      checkOutput($sformatf("rnd%0d.model(n%0d o%0d d%0d)", i, note, oct, dur), m.modelMismatch, 0);
      checkOutput($sformatf("rnd%0d.busyCycles", i), m.busyCycles, (dur + GAP_TICKS) * P);
      checkOutput($sformatf("rnd%0d.ampCycles", i), m.ampCycles, (note < 12) ? dur * P : 0);
      checkOutput($sformatf("rnd%0d.doneCount", i), m.doneCount, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
